atuador_de_porta: RTL and testbench
===================================

// Module: atuador_de_porta
// PURPOSE
//  Motor-side sequencer for the automatic door: receives the open request
//  produced by the door-opener logic and drives the door motor. Reads the
//  limit switches and the obstacle sensor, holds the door open for a
//  programmable time, then closes it. Stops the door on travel timeout or
//  on inconsistent sensors. Sits between the opener decision logic and the
//  motor driver.
// PARAMETERS
//  HOLD_CYCLES     4'd? default 50   cycles door stays open after last abrir_req
//  TIMEOUT_CYCLES  default 200       max cycles for one open/close travel before FALHA
// PORTS
//  clk          in   1  single system clock, rising edge
//  rst          in   1  reset, asynchronous, active-high
//  abrir_req    in   1  open request from opener logic (level, held while wanted)
//  fim_aberta   in   1  limit switch: door fully open
//  fim_fechada  in   1  limit switch: door fully closed
//  obstaculo    in   1  obstacle in doorway
//  motor_abrir  out  1  drive motor in opening direction
//  motor_fechar out  1  drive motor in closing direction
//  porta_aberta out  1  door held open (state ABERTA)
//  falha        out  1  fault latched (state FALHA)
// BEHAVIOUR
//  - Moore FSM. Outputs decode the state register only. Inputs are synchronous to clk.
//  - States: FECHADA, ABRINDO, ABERTA, FECHANDO, PARADA (macro off only), FALHA.
//  - One timer, width $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1). Cleared on every
//    state change. Saturates, never wraps.
//  - rst=1: state FECHADA, timer 0, all outputs 0 immediately (async).
//    A reset mid-travel stops the motor the same instant.
//  - Outputs: motor_abrir=ABRINDO; motor_fechar=FECHANDO;
//    porta_aberta=ABERTA; falha=FALHA. The two motor outputs are never both 1.
//  - Transition priority, highest first, from any state except FALHA:
//    fim_aberta&fim_fechada (inconsistent sensors) -> FALHA.
//  - FECHADA: abrir_req -> ABRINDO. Else if fim_fechada=0 -> FECHANDO
//    (recovers a door left ajar after reset).
//  - ABRINDO: fim_aberta -> ABERTA. Else timer==TIMEOUT_CYCLES-1 -> FALHA.
//  - ABERTA: abrir_req=1 reloads timer to 0. Timer==HOLD_CYCLES-1 with
//    abrir_req=0 and obstaculo=0 -> FECHANDO. obstaculo=1 keeps the timer at 0.
//  - FECHANDO: abrir_req -> ABRINDO. Else obstaculo -> see CONFIGURATION.
//    Else fim_fechada -> FECHADA. Else timer==TIMEOUT_CYCLES-1 -> FALHA.
//  - FALHA: absorbing. Motors off. Only rst exits.
//  - Latency: request sampled at edge N -> motor_abrir=1 after edge N
//    (1 cycle). Limit switch at edge N -> motor off after edge N.
// CONFIGURATION
//  REABERTURA_EN defined: obstaculo in FECHANDO -> ABRINDO, so the door reopens.
//    PARADA does not exist.
//  REABERTURA_EN undefined: obstaculo in FECHANDO -> PARADA, with both motors
//    off. PARADA: abrir_req -> ABRINDO. obstaculo=0 -> FECHANDO (timer restarts).
//    Both limits -> FALHA. No timeout in PARADA.
// TESTING (HOLD_CYCLES=4, TIMEOUT_CYCLES=8)
//  1 rst, fim_fechada=1, abrir_req pulse 1 cycle -> motor_abrir=1 next cycle.
//    Then fim_aberta=1 at cycle 3 -> porta_aberta=1. 4 cycles later
//    motor_fechar=1. fim_fechada=1 -> all outputs 0.
//  2 abrir_req held high 20 cycles in ABERTA -> porta_aberta stays 1.
//    Closing starts exactly 4 cycles after the request drops.
//  3 ABRINDO with fim_aberta never set -> falha=1 after 8 cycles, motors 0.
//    Stays in FALHA despite abrir_req. Exits only on rst.
//  4 obstaculo=1 during FECHANDO -> macro on: motor_abrir=1 next cycle.
//    Macro off: both motors 0, then motor_fechar=1 one cycle after obstaculo=0.
//  5 fim_aberta=fim_fechada=1 in FECHADA -> falha=1 next cycle.
//  6 rst asserted mid-ABRINDO, between clock edges -> motor_abrir=0 at once.
//    Release with fim_fechada=0 -> FECHANDO next cycle.

Source files
------------

// File: rtl/atuador_de_porta.sv
// atuador_de_porta: motor-side sequencer for the automatic door (open, hold, close, fault).
// Optional macro REABERTURA_EN: an obstacle while closing reopens the door instead of stopping it.
module atuador_de_porta #(
   parameter int HOLD_CYCLES    = 50,
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic abrir_req,
   input  logic fim_aberta,
   input  logic fim_fechada,
   input  logic obstaculo,
   output logic motor_abrir,
   output logic motor_fechar,
   output logic porta_aberta,
   output logic falha
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
   localparam int TW = $clog2(MAX_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_MAX   = TW'(MAX_CYCLES);
   localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef REABERTURA_EN
   typedef enum logic [2:0] {FECHADA, ABRINDO, ABERTA, FECHANDO, FALHA} estado_t;
`else
   typedef enum logic [2:0] {FECHADA, ABRINDO, ABERTA, FECHANDO, PARADA, FALHA} estado_t;
`endif

   estado_t       estado;
   estado_t       prox_estado;
   logic [TW-1:0] timer;
   logic [TW-1:0] prox_timer;

   always_comb begin
      prox_estado = estado;
      prox_timer  = timer;
      case (estado)
         FECHADA: begin
            if (abrir_req)
               prox_estado = ABRINDO;
            else if (!fim_fechada)
               prox_estado = FECHANDO;
         end
         ABRINDO: begin
            if (fim_aberta)
               prox_estado = ABERTA;
            else if (timer == TRAVEL_LAST)
               prox_estado = FALHA;
         end
         ABERTA: begin
            if (!abrir_req && !obstaculo && timer == HOLD_LAST)
               prox_estado = FECHANDO;
         end
         FECHANDO: begin
            if (abrir_req)
               prox_estado = ABRINDO;
            else if (obstaculo)
`ifdef REABERTURA_EN
               prox_estado = ABRINDO;
`else
               prox_estado = PARADA;
`endif
            else if (fim_fechada)
               prox_estado = FECHADA;
            else if (timer == TRAVEL_LAST)
               prox_estado = FALHA;
         end
`ifndef REABERTURA_EN
         PARADA: begin
            if (abrir_req)
               prox_estado = ABRINDO;
            else if (!obstaculo)
               prox_estado = FECHANDO;
         end
`endif
         default: prox_estado = FALHA;
      endcase

      // Contradictory limit switches override every other decision
      if (estado != FALHA && fim_aberta && fim_fechada)
         prox_estado = FALHA;

      if (prox_estado != estado)
         prox_timer = '0;
      else if (estado == ABERTA && (abrir_req || obstaculo))
         prox_timer = '0;
      else if (timer != TIMER_MAX)
         prox_timer = timer + 1'b1;
   end

   // Outputs are registered from the next state so they always match the state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado       <= FECHADA;
         timer        <= '0;
         motor_abrir  <= 1'b0;
         motor_fechar <= 1'b0;
         porta_aberta <= 1'b0;
         falha        <= 1'b0;
      end else begin
         estado       <= prox_estado;
         timer        <= prox_timer;
         motor_abrir  <= (prox_estado == ABRINDO);
         motor_fechar <= (prox_estado == FECHANDO);
         porta_aberta <= (prox_estado == ABERTA);
         falha        <= (prox_estado == FALHA);
      end
   end

endmodule

// File: tb/tb_atuador_de_porta.sv
// tb_atuador_de_porta: directed scenarios for the door sequencer, checked every cycle
// against a behavioural door model plus hand-computed literal expectations.
module tb_atuador_de_porta;

   localparam int HOLD = 4;
   localparam int TMO  = 8;

   localparam int M_CLOSED  = 0;
   localparam int M_OPENING = 1;
   localparam int M_OPEN    = 2;
   localparam int M_CLOSING = 3;
   localparam int M_STOPPED = 4;
   localparam int M_FAULT   = 5;

   logic clk = 1'b0;
   logic rst;
   logic abrir_req, fim_aberta, fim_fechada, obstaculo;
   logic motor_abrir, motor_fechar, porta_aberta, falha;

   int vectors     = 0;
   int miscompares = 0;
   int mode        = M_CLOSED;
   int dwell       = 0;
   int quiet       = 0;

   atuador_de_porta #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .abrir_req(abrir_req), .fim_aberta(fim_aberta),
      .fim_fechada(fim_fechada), .obstaculo(obstaculo),
      .motor_abrir(motor_abrir), .motor_fechar(motor_fechar),
      .porta_aberta(porta_aberta), .falha(falha)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] model_out(input int m);
      return {m == M_OPENING, m == M_CLOSING, m == M_OPEN, m == M_FAULT};
   endfunction

   // Door model: dwell counts edges spent in the current mode, quiet counts idle edges while open
   always @(posedge clk or posedge rst) begin : model_step
      int nxt;
      if (rst) begin
         mode  = M_CLOSED;
         dwell = 0;
         quiet = 0;
      end else begin
         nxt = mode;
         if (mode == M_FAULT)
            nxt = M_FAULT;
         else if (fim_aberta && fim_fechada)
            nxt = M_FAULT;
         else if (mode == M_CLOSED)
            nxt = abrir_req ? M_OPENING : (!fim_fechada ? M_CLOSING : M_CLOSED);
         else if (mode == M_OPENING) begin
            if (fim_aberta) nxt = M_OPEN;
            else if (dwell + 1 >= TMO) nxt = M_FAULT;
         end else if (mode == M_OPEN) begin
            if (abrir_req || obstaculo) quiet = 0;
            else if (quiet + 1 >= HOLD) nxt = M_CLOSING;
            else quiet++;
         end else if (mode == M_CLOSING) begin
            if (abrir_req) nxt = M_OPENING;
`ifdef REABERTURA_EN
            else if (obstaculo) nxt = M_OPENING;
`else
            else if (obstaculo) nxt = M_STOPPED;
`endif
            else if (fim_fechada) nxt = M_CLOSED;
            else if (dwell + 1 >= TMO) nxt = M_FAULT;
         end else if (mode == M_STOPPED) begin
            if (abrir_req) nxt = M_OPENING;
            else if (!obstaculo) nxt = M_CLOSING;
         end
         if (nxt != mode) begin
            dwell = 0;
            quiet = 0;
         end else
            dwell++;
         mode = nxt;
      end
   end

   // Per-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      logic [3:0] got;
      got = {motor_abrir, motor_fechar, porta_aberta, falha};
      vectors++;
      if (got !== model_out(mode)) begin
         miscompares++;
         $display("[TB] FAIL cycle_check t=%0t: got %b expected %b", $time, got, model_out(mode));
      end
   end

   task automatic checkOutput(input string name, input logic [3:0] exp);
      logic [3:0] got;
      got = {motor_abrir, motor_fechar, porta_aberta, falha};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: dut got %b expected %b", name, got, exp);
      end
      vectors++;
      if (model_out(mode) !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s_model: model got %b expected %b", name, model_out(mode), exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic fa, input logic ff,
                                input logic obs, input int n);
      abrir_req   = req;
      fim_aberta  = fa;
      fim_fechada = ff;
      obstaculo   = obs;
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      abrir_req = 1'b0; fim_aberta = 1'b0; fim_fechada = 1'b1; obstaculo = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset", 4'b0000);
      rst = 1'b0;

      // Scenario 1: full open, hold, close cycle
      applyStimulus(1, 0, 1, 0, 1);  checkOutput("t1_req",     4'b1000);
      applyStimulus(0, 0, 0, 0, 1);  checkOutput("t1_opening", 4'b1000);
      applyStimulus(0, 1, 0, 0, 1);  checkOutput("t1_open",    4'b0010);
      applyStimulus(0, 0, 0, 0, 3);  checkOutput("t1_hold",    4'b0010);
      applyStimulus(0, 0, 0, 0, 1);  checkOutput("t1_close",   4'b0100);
      applyStimulus(0, 0, 0, 0, 2);  checkOutput("t1_closing", 4'b0100);
      applyStimulus(0, 0, 1, 0, 1);  checkOutput("t1_closed",  4'b0000);

      // Scenario 2: request held while open keeps the door open
      applyStimulus(1, 0, 1, 0, 1);  checkOutput("t2_req",     4'b1000);
      applyStimulus(1, 1, 0, 0, 1);  checkOutput("t2_open",    4'b0010);
      applyStimulus(1, 0, 0, 0, 20); checkOutput("t2_held",    4'b0010);
      applyStimulus(0, 0, 0, 0, 3);  checkOutput("t2_hold",    4'b0010);
      applyStimulus(0, 0, 0, 0, 1);  checkOutput("t2_close",   4'b0100);
      applyStimulus(0, 0, 1, 0, 1);  checkOutput("t2_closed",  4'b0000);

      // Scenario 4: obstacle during closing
      applyStimulus(1, 0, 1, 0, 1);  checkOutput("t4_req",     4'b1000);
      applyStimulus(0, 1, 0, 0, 1);  checkOutput("t4_open",    4'b0010);
      applyStimulus(0, 0, 0, 0, 4);  checkOutput("t4_closing", 4'b0100);
`ifdef REABERTURA_EN
      applyStimulus(0, 0, 0, 1, 1);  checkOutput("t4_reopen",  4'b1000);
      applyStimulus(0, 1, 0, 0, 1);  checkOutput("t4_open2",   4'b0010);
      applyStimulus(0, 0, 0, 0, 4);  checkOutput("t4_close2",  4'b0100);
`else
      applyStimulus(0, 0, 0, 1, 1);  checkOutput("t4_stop",    4'b0000);
      applyStimulus(0, 0, 0, 1, 10); checkOutput("t4_stopped", 4'b0000);
      applyStimulus(0, 0, 0, 0, 1);  checkOutput("t4_resume",  4'b0100);
`endif
      applyStimulus(0, 0, 1, 0, 1);  checkOutput("t4_closed",  4'b0000);

      // Scenario 5: both limit switches while closed
      applyStimulus(0, 1, 1, 0, 1);  checkOutput("t5_fault",   4'b0001);
      applyStimulus(1, 0, 1, 0, 3);  checkOutput("t5_absorb",  4'b0001);

      // Scenario 3: opening timeout
      rst = 1'b1;
      #1;
      checkOutput("t3_reset", 4'b0000);
      @(posedge clk);
      #2;
      rst = 1'b0;
      applyStimulus(1, 0, 1, 0, 1);  checkOutput("t3_req",     4'b1000);
      applyStimulus(0, 0, 0, 0, 6);  checkOutput("t3_travel",  4'b1000);
      applyStimulus(0, 0, 0, 0, 1);  checkOutput("t3_last",    4'b1000);
      applyStimulus(0, 0, 0, 0, 1);  checkOutput("t3_timeout", 4'b0001);
      applyStimulus(1, 0, 0, 0, 3);  checkOutput("t3_absorb",  4'b0001);

      // Scenario 6: asynchronous reset mid-opening, door left ajar
      rst = 1'b1;
      applyStimulus(0, 0, 1, 0, 1);
      rst = 1'b0;
      applyStimulus(1, 0, 1, 0, 1);  checkOutput("t6_req",     4'b1000);
      applyStimulus(0, 0, 0, 0, 2);  checkOutput("t6_opening", 4'b1000);
      #4;
      rst = 1'b1;
      #1;
      checkOutput("t6_async", 4'b0000);
      @(posedge clk);
      #2;
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 1);  checkOutput("t6_recover", 4'b0100);
      applyStimulus(0, 0, 1, 0, 1);  checkOutput("t6_closed",  4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
